// File: rtl/qam_pkg.sv
// Shared constants for the 16-QAM IF path: Gray level codes, IF midscale,
// carrier phase encoding and serializer states.
package qam_pkg;

   localparam logic [1:0] G_P3 = 2'b10;
   localparam logic [1:0] G_P1 = 2'b11;
   localparam logic [1:0] G_M1 = 2'b01;
   localparam logic [1:0] G_M3 = 2'b00;

   localparam logic [17:0] MIDSCALE = 18'd131072;

   // fs/4 carrier phases: which axis a sample lands on, and with which sign
   localparam logic [1:0] PH_I_POS = 2'd0;
   localparam logic [1:0] PH_Q_NEG = 2'd1;
   localparam logic [1:0] PH_I_NEG = 2'd2;
   localparam logic [1:0] PH_Q_POS = 2'd3;

   typedef enum logic {
      SER_IDLE,
      SER_SHIFT
   } ser_state_t;

endpackage

// File: rtl/qam_slicer.sv
// Combinational 4-level slicer: integrated axis value to 16-QAM Gray bits.
module qam_slicer
   import qam_pkg::*;
#(
   parameter int ACC_W = 22,
   parameter int THR   = 131072
) (
   input  logic signed [ACC_W-1:0] v,
   output logic        [1:0]       gray
);

   localparam logic signed [ACC_W-1:0] THR_POS = ACC_W'(THR);
   localparam logic signed [ACC_W-1:0] THR_NEG = ACC_W'(-THR);

   // zero belongs to +1 and -THR belongs to -1
   always_comb begin
      gray = G_M3;
      if (v >= THR_POS)
         gray = G_P3;
      else if (!v[ACC_W-1])
         gray = G_P1;
      else if (v >= THR_NEG)
         gray = G_M1;
   end

endmodule

// File: rtl/if_qam16_demod.sv
// fs/4 coherent IF demodulator: mix, integrate-and-dump per symbol, slice to
// 16-QAM Gray bits and serialize them MSB first.
module if_qam16_demod
   import qam_pkg::*;
#(
   parameter int SPS   = 16,
   parameter int ACC_W = 18 + $clog2(SPS),
   parameter int THR   = 131072
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [17:0] IFin,
   output logic [3:0]  sym,
   output logic        sym_valid,
   output logic        Bout,
   output logic        bout_valid
);

   localparam int CNT_W = $clog2(SPS);

   logic signed [17:0]      s;
   logic signed [ACC_W-1:0] s_ext;
   logic signed [ACC_W-1:0] acc_i_reg, acc_q_reg, acc_i_next, acc_q_next;
   logic [CNT_W-1:0]        cnt_reg;
   logic [1:0]              ph_reg;
   logic                    last_sample;
   logic signed [ACC_W-1:0] dump_reg [2];
   logic                    dump_valid_reg;
   logic [1:0]              gray [2];
   logic [3:0]              sym_reg;
   logic                    sym_valid_reg;

   ser_state_t state_reg, state_next;
   logic [3:0] shift_reg, shift_next;
   logic [1:0] bcnt_reg, bcnt_next;
   logic       bout_reg, bout_next;
   logic       bout_valid_reg, bout_valid_next;

   assign s           = $signed(IFin - MIDSCALE);
   assign s_ext       = {{(ACC_W-18){s[17]}}, s};
   assign last_sample = en && (cnt_reg == CNT_W'(SPS-1));

   always_comb begin
      acc_i_next = acc_i_reg;
      acc_q_next = acc_q_reg;
      case (ph_reg)
         PH_I_POS: acc_i_next = acc_i_reg + s_ext;
         PH_Q_NEG: acc_q_next = acc_q_reg - s_ext;
         PH_I_NEG: acc_i_next = acc_i_reg - s_ext;
         default:  acc_q_next = acc_q_reg + s_ext;
      endcase
   end

   // en=0 aborts the symbol in progress; the dump stage still drains
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_i_reg      <= '0;
         acc_q_reg      <= '0;
         cnt_reg        <= '0;
         ph_reg         <= '0;
         dump_reg[0]    <= '0;
         dump_reg[1]    <= '0;
         dump_valid_reg <= 1'b0;
         sym_reg        <= '0;
         sym_valid_reg  <= 1'b0;
      end else begin
         if (!en) begin
            acc_i_reg <= '0;
            acc_q_reg <= '0;
            cnt_reg   <= '0;
            ph_reg    <= '0;
         end else if (last_sample) begin
            acc_i_reg <= '0;
            acc_q_reg <= '0;
            cnt_reg   <= '0;
            ph_reg    <= ph_reg + 2'd1;
         end else begin
            acc_i_reg <= acc_i_next;
            acc_q_reg <= acc_q_next;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            ph_reg    <= ph_reg + 2'd1;
         end
         dump_valid_reg <= last_sample;
         if (last_sample) begin
            dump_reg[0] <= acc_i_next;
            dump_reg[1] <= acc_q_next;
         end
         sym_valid_reg <= dump_valid_reg;
         if (dump_valid_reg)
            sym_reg <= {gray[0], gray[1]};
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_slicer
      qam_slicer #(.ACC_W(ACC_W), .THR(THR)) u_slicer (
         .v    (dump_reg[gi]),
         .gray (gray[gi])
      );
   end

   always_comb begin
      state_next      = state_reg;
      shift_next      = shift_reg;
      bcnt_next       = bcnt_reg;
      bout_next       = 1'b0;
      bout_valid_next = 1'b0;
      case (state_reg)
         SER_IDLE: begin
            if (sym_valid_reg) begin
               bout_next       = sym_reg[3];
               bout_valid_next = 1'b1;
               shift_next      = {sym_reg[2:0], 1'b0};
               bcnt_next       = 2'd0;
               state_next      = SER_SHIFT;
            end
         end
         default: begin
            bout_next       = shift_reg[3];
            bout_valid_next = 1'b1;
            shift_next      = {shift_reg[2:0], 1'b0};
            bcnt_next       = bcnt_reg + 2'd1;
            if (bcnt_reg == 2'd2)
               state_next = SER_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= SER_IDLE;
         shift_reg      <= '0;
         bcnt_reg       <= '0;
         bout_reg       <= 1'b0;
         bout_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         shift_reg      <= shift_next;
         bcnt_reg       <= bcnt_next;
         bout_reg       <= bout_next;
         bout_valid_reg <= bout_valid_next;
      end
   end

   assign sym        = sym_reg;
   assign sym_valid  = sym_valid_reg;
   assign Bout       = bout_reg;
   assign bout_valid = bout_valid_reg;

endmodule

// File: tb/tb_if_qam16_demod.sv
// Self-checking bench for if_qam16_demod against an arithmetic symbol model.
module tb_if_qam16_demod;

   localparam int SPS = 16;
   localparam int THR = 131072;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic [17:0] IFin = '0;
   logic [3:0]  sym;
   logic        sym_valid;
   logic        Bout;
   logic        bout_valid;

   int n_cmp = 0;
   int n_bad = 0;

   if_qam16_demod #(.SPS(SPS), .THR(THR)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .IFin       (IFin),
      .sym        (sym),
      .sym_valid  (sym_valid),
      .Bout       (Bout),
      .bout_valid (bout_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] gray_of(input longint v);
      if (v >= THR)       return 2'b10;
      else if (v >= 0)    return 2'b11;
      else if (v >= -THR) return 2'b01;
      else                return 2'b00;
   endfunction

   // carrier cos/-sin at fs/4 is {1,0,-1,0} for I and {0,-1,0,1} for Q
   function automatic logic [3:0] model_sym(input int cs[SPS]);
      longint ai, aq;
      ai = 0;
      aq = 0;
      for (int k = 0; k < SPS; k++) begin
         case (k % 4)
            0:       ai += cs[k];
            1:       aq -= cs[k];
            2:       ai -= cs[k];
            default: aq += cs[k];
         endcase
      end
      return {gray_of(ai), gray_of(aq)};
   endfunction

   task automatic drive_samples(input int cs[SPS], input int n, output int sv_seen);
      sv_seen = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (sym_valid) sv_seen++;
         en   = 1'b1;
         IFin = 18'(cs[k] + 131072);
      end
   endtask

   task automatic collect(output int lat, output logic [3:0] s_obs, output logic [3:0] bits,
                          output logic [4:0] bv, output logic sv_after);
      bit seen;
      seen = 0;
      lat = -1;
      s_obs = '0;
      bits = '0;
      bv = '0;
      sv_after = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         if (!seen) begin
            @(negedge clk);
            en = 1'b0;
            if (sym_valid) begin
               seen  = 1;
               lat   = n;
               s_obs = sym;
            end
         end
      end
      if (seen) begin
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) sv_after = sym_valid;
            bits[3-i] = Bout;
            bv[4-i]   = bout_valid;
         end
         @(negedge clk);
         bv[0] = bout_valid;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      en    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         IFin = 18'($urandom);
         n_cmp++;
         if ({sym, sym_valid, Bout, bout_valid} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_outputs cycle %0d got %b required 0", i,
                     {sym, sym_valid, Bout, bout_valid});
         end
      end
      @(negedge clk);
      en    = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_symbols();
      int cs[SPS];
      logic [3:0] exp_tab [7];
      int early, lat;
      logic [3:0] s_obs, bits;
      logic [4:0] bv;
      logic sv_after;
      exp_tab = '{4'b1111, 4'b1011, 4'b0011, 4'b1011, 4'b0111, 4'b0011, 4'b1111};
      for (int t = 0; t < 7; t++) begin
         for (int k = 0; k < SPS; k++) begin
            case (t)
               1: cs[k] = (k % 4 == 0) ? 20000 : (k % 4 == 2) ? -20000 : 0;
               2: cs[k] = (k % 4 == 0) ? -20000 : (k % 4 == 1) ? -5000 :
                          (k % 4 == 2) ? 20000 : 5000;
               3: cs[k] = (k == 0) ? 131071 : (k == 4) ? 1 : 0;
               4: cs[k] = (k == 0) ? -131072 : 0;
               5: cs[k] = (k == 0) ? -131072 : (k == 4) ? -1 : 0;
               6: cs[k] = (k == 0) ? 131071 : 0;
               default: cs[k] = 0;
            endcase
         end
         drive_samples(cs, SPS, early);
         collect(lat, s_obs, bits, bv, sv_after);
         n_cmp += 4;
         if (lat !== 2 || early !== 0) begin
            n_bad++;
            $display("FAIL dir%0d_latency got lat=%0d early=%0d required lat=2 early=0", t, lat, early);
         end
         if (s_obs !== exp_tab[t]) begin
            n_bad++;
            $display("FAIL dir%0d_sym got %b required %b", t, s_obs, exp_tab[t]);
         end
         if (bits !== exp_tab[t]) begin
            n_bad++;
            $display("FAIL dir%0d_bout got %b required %b", t, bits, exp_tab[t]);
         end
         if (bv !== 5'b11110 || sv_after !== 1'b0) begin
            n_bad++;
            $display("FAIL dir%0d_valids got bv=%b sv_after=%b required bv=11110 sv_after=0",
                     t, bv, sv_after);
         end
      end
   endtask

   task automatic test_random();
      int cs[SPS];
      int range, early, lat;
      logic [3:0] s_obs, bits, exp_s;
      logic [4:0] bv;
      logic sv_after;
      for (int t = 0; t < 12; t++) begin
         case ($urandom_range(0, 2))
            0:       range = 2000;
            1:       range = 40000;
            default: range = 131072;
         endcase
         for (int k = 0; k < SPS; k++)
            cs[k] = int'($urandom_range(0, 2 * range - 1)) - range;
         exp_s = model_sym(cs);
         drive_samples(cs, SPS, early);
         collect(lat, s_obs, bits, bv, sv_after);
         n_cmp += 3;
         if (lat !== 2 || early !== 0) begin
            n_bad++;
            $display("FAIL rnd%0d_latency got lat=%0d early=%0d required lat=2 early=0", t, lat, early);
         end
         if (s_obs !== exp_s || bits !== exp_s) begin
            n_bad++;
            $display("FAIL rnd%0d_sym got sym=%b bits=%b required %b", t, s_obs, bits, exp_s);
         end
         if (bv !== 5'b11110) begin
            n_bad++;
            $display("FAIL rnd%0d_bout_valid got %b required 11110", t, bv);
         end
      end
   endtask

   task automatic test_abort();
      int cs[SPS];
      int early, lat, sv_cnt;
      logic [3:0] s_obs, bits;
      logic [4:0] bv;
      logic sv_after;
      for (int k = 0; k < SPS; k++)
         cs[k] = int'($urandom_range(0, 200000)) - 100000;
      drive_samples(cs, 10, early);
      sv_cnt = early;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en = 1'b0;
         if (sym_valid) sv_cnt++;
      end
      for (int k = 0; k < SPS; k++)
         cs[k] = (k % 4 == 0) ? -20000 : (k % 4 == 2) ? 20000 : 0;
      drive_samples(cs, SPS, early);
      sv_cnt += early;
      collect(lat, s_obs, bits, bv, sv_after);
      n_cmp += 3;
      if (sv_cnt !== 0) begin
         n_bad++;
         $display("FAIL abort_no_sym got %0d sym_valid pulses required 0", sv_cnt);
      end
      if (lat !== 2) begin
         n_bad++;
         $display("FAIL abort_resume_latency got %0d required 2", lat);
      end
      if (s_obs !== 4'b0011) begin
         n_bad++;
         $display("FAIL abort_resume_sym got %b required 0011", s_obs);
      end
      // en falls exactly on the last sample of a symbol
      drive_samples(cs, SPS - 1, early);
      sv_cnt = early;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         en = 1'b0;
         if (sym_valid || bout_valid) sv_cnt++;
      end
      n_cmp++;
      if (sv_cnt !== 0) begin
         n_bad++;
         $display("FAIL abort_last_sample got %0d valid cycles required 0", sv_cnt);
      end
   endtask

   task automatic test_reset_mid_serial();
      int cs[SPS];
      int early, n, seen_cnt;
      for (int k = 0; k < SPS; k++) cs[k] = 0;
      drive_samples(cs, SPS, early);
      n = 0;
      while (!sym_valid && n < 10) begin
         @(negedge clk);
         en = 1'b0;
         n++;
      end
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (bout_valid !== 1'b1 || Bout !== 1'b1) begin
         n_bad++;
         $display("FAIL midser_second_bit got bv=%b bout=%b required 1 1", bout_valid, Bout);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({sym, sym_valid, Bout, bout_valid} !== 7'd0) begin
         n_bad++;
         $display("FAIL midser_async_clear got %b required 0", {sym, sym_valid, Bout, bout_valid});
      end
      @(negedge clk);
      reset = 1'b1;
      seen_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bout_valid || sym_valid) seen_cnt++;
      end
      n_cmp++;
      if (seen_cnt !== 0) begin
         n_bad++;
         $display("FAIL midser_after_release got %0d valid cycles required 0", seen_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_symbols();
      test_random();
      test_abort();
      test_reset_mid_serial();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
